// File: rtl/gear_input_conditioner_if.sv
// Purpose: groups the controller-facing signals of the gear input conditioner.
// Latency: none (wires only).
// Backpressure: none; every signal is a level that is sampled each cycle.
interface gear_input_conditioner_if;
    logic Timer;
    logic LeverRaw;
    logic GearIsDownRaw;
    logic GearIsUpRaw;
    logic PlaneOnGroundRaw;
    logic Lever;
    logic GearIsDown;
    logic GearIsUp;
    logic PlaneOnGround;
    logic TimeUp;
    logic SensorFault;

    // Controller / sensor side: drives raw inputs and Timer, consumes conditioned outputs.
    modport master (
        output Timer, LeverRaw, GearIsDownRaw, GearIsUpRaw, PlaneOnGroundRaw,
        input  Lever, GearIsDown, GearIsUp, PlaneOnGround, TimeUp, SensorFault
    );

    // Conditioner side.
    modport slave (
        input  Timer, LeverRaw, GearIsDownRaw, GearIsUpRaw, PlaneOnGroundRaw,
        output Lever, GearIsDown, GearIsUp, PlaneOnGround, TimeUp, SensorFault
    );
endinterface

// File: rtl/gear_input_conditioner.sv
// Purpose: sync + debounce gear/cockpit inputs, takeoff timeout timer, sticky sensor-fault flag.
// Latency: 2 cycles sync, plus DB_TICKS-1..DB_TICKS ticks debounce; TimeUp after TIMEOUT_TICKS ticks.
// Backpressure: none; inputs are levels. Define GEAR_COND_DB_BYPASS_EN to drop the debounce stage.
module gear_input_conditioner #(
    parameter int TICK_DIV      = 1000,
    parameter int DB_TICKS      = 8,
    parameter int TIMEOUT_TICKS = 2000,
    parameter int CNT_W         = 12
) (
    input  logic                       Clock,
    input  logic                       Clear,
    gear_input_conditioner_if.slave    gif
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W  = $clog2(DB_TICKS + 1);
    // Bit order {Lever, GearIsDown, GearIsUp, PlaneOnGround}: parked on ground, gear down.
    localparam logic [3:0] RST_VAL = 4'b1101;

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_EXPIRED} tstate_t;

    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       cond;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    tstate_t          state;
    tstate_t          state_nxt;
    logic [CNT_W-1:0] tcnt;
    logic [CNT_W-1:0] tcnt_nxt;
    logic             time_up;
    logic             time_up_nxt;
    logic             fault;

    assign raw = {gif.LeverRaw, gif.GearIsDownRaw, gif.GearIsUpRaw, gif.PlaneOnGroundRaw};

    // Two-flop synchronizer; flops park at the safe on-ground values.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Free-running timebase; only Clear restarts it so tick phase is independent of Timer.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_W'(TICK_DIV - 1)) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

`ifdef GEAR_COND_DB_BYPASS_EN
    assign cond = sync2;
`else
    logic [DB_W-1:0] db_cnt [4];

    // Per-input debounce: output follows sync only after DB_TICKS consecutive differing ticks.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            cond <= RST_VAL;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == cond[i]) begin
                    db_cnt[i] <= '0;
                end else if (tick) begin
                    if (db_cnt[i] == DB_W'(DB_TICKS - 1)) begin
                        cond[i]   <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end
`endif

    // Timer FSM state register.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state   <= T_IDLE;
            tcnt    <= '0;
            time_up <= 1'b0;
        end else begin
            state   <= state_nxt;
            tcnt    <= tcnt_nxt;
            time_up <= time_up_nxt;
        end
    end

    // Timer FSM next state: Timer=1 wins over tick; counting begins one cycle after leaving IDLE.
    always_comb begin
        state_nxt   = state;
        tcnt_nxt    = tcnt;
        time_up_nxt = time_up;
        if (gif.Timer) begin
            state_nxt   = T_IDLE;
            tcnt_nxt    = '0;
            time_up_nxt = 1'b0;
        end else begin
            case (state)
                T_IDLE: begin
                    state_nxt = T_RUN;
                end
                T_RUN: begin
                    if (tick) begin
                        tcnt_nxt = tcnt + 1'b1;
                        if (tcnt_nxt == CNT_W'(TIMEOUT_TICKS)) begin
                            state_nxt   = T_EXPIRED;
                            time_up_nxt = 1'b1;
                        end
                    end
                end
                T_EXPIRED: begin
                    time_up_nxt = 1'b1;
                end
                default: begin
                    state_nxt = T_IDLE;
                    tcnt_nxt  = '0;
                end
            endcase
        end
    end

    // Sticky flag for both gear sensors reading asserted at once; cleared only by Clear.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            fault <= 1'b0;
        end else if (cond[2] && cond[1]) begin
            fault <= 1'b1;
        end
    end

    assign gif.Lever         = cond[3];
    assign gif.GearIsDown    = cond[2];
    assign gif.GearIsUp      = cond[1];
    assign gif.PlaneOnGround = cond[0];
    assign gif.TimeUp        = time_up;
    assign gif.SensorFault   = fault;

endmodule

// File: tb/tb_gear_input_conditioner.sv
// Purpose: self-checking bench for gear_input_conditioner (directed table plus random vs. model).
// Latency: n/a.
// Backpressure: n/a.
module tb_gear_input_conditioner;

    localparam int TICK_DIV      = 4;
    localparam int DB_TICKS      = 3;
    localparam int TIMEOUT_TICKS = 5;
    localparam int CNT_W         = 4;
    localparam logic [3:0] RST_VAL = 4'b1101;

    logic Clock;
    logic Clear;

    gear_input_conditioner_if gif ();

    gear_input_conditioner #(
        .TICK_DIV     (TICK_DIV),
        .DB_TICKS     (DB_TICKS),
        .TIMEOUT_TICKS(TIMEOUT_TICKS),
        .CNT_W        (CNT_W)
    ) dut (
        .Clock(Clock),
        .Clear(Clear),
        .gif  (gif)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state: edges since Clear, raw history, outputs, debounce streaks, timer.
    int         m_k;
    logic [3:0] hist[$];
    logic [3:0] m_out;
    int         m_streak[4];
    int         m_ticks;
    bit         m_armed;
    logic       m_timeup;
    logic       m_fault;

    typedef struct {
        logic lever, down, up, pog, timer;
        int   hold;
        logic e_lever, e_down, e_up, e_pog, e_timeup, e_fault;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl[NV];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_k = 0;
        hist.delete();
        m_out = RST_VAL;
        for (int i = 0; i < 4; i++) m_streak[i] = 0;
        m_ticks  = 0;
        m_armed  = 1'b0;
        m_timeup = 1'b0;
        m_fault  = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs held during that edge.
    task automatic model_update();
        logic [3:0] r;
        logic [3:0] s2;
        bit         tick;
        r    = {gif.LeverRaw, gif.GearIsDownRaw, gif.GearIsUpRaw, gif.PlaneOnGroundRaw};
        tick = ((m_k % TICK_DIV) == TICK_DIV - 1);
        if (m_out[2] && m_out[1]) m_fault = 1'b1;
`ifdef GEAR_COND_DB_BYPASS_EN
        s2 = (hist.size() >= 1) ? hist[0] : RST_VAL;
        m_out = s2;
`else
        s2 = (hist.size() >= 2) ? hist[1] : RST_VAL;
        for (int i = 0; i < 4; i++) begin
            if (s2[i] == m_out[i]) begin
                m_streak[i] = 0;
            end else if (tick) begin
                m_streak[i]++;
                if (m_streak[i] == DB_TICKS) begin
                    m_out[i]    = s2[i];
                    m_streak[i] = 0;
                end
            end
        end
`endif
        if (gif.Timer) begin
            m_ticks  = 0;
            m_armed  = 1'b0;
            m_timeup = 1'b0;
        end else begin
            if (m_armed && !m_timeup && tick) begin
                m_ticks++;
                if (m_ticks == TIMEOUT_TICKS) m_timeup = 1'b1;
            end
            m_armed = 1'b1;
        end
        hist.push_front(r);
        if (hist.size() > 2) void'(hist.pop_back());
        m_k++;
    endtask

    task automatic step();
        @(posedge Clock);
        model_update();
        @(negedge Clock);
        check("model_Lever",         gif.Lever,         m_out[3]);
        check("model_GearIsDown",    gif.GearIsDown,    m_out[2]);
        check("model_GearIsUp",      gif.GearIsUp,      m_out[1]);
        check("model_PlaneOnGround", gif.PlaneOnGround, m_out[0]);
        check("model_TimeUp",        gif.TimeUp,        m_timeup);
        check("model_SensorFault",   gif.SensorFault,   m_fault);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_Lever"},         gif.Lever,         1'b1);
        check({tag, "_GearIsDown"},    gif.GearIsDown,    1'b1);
        check({tag, "_GearIsUp"},      gif.GearIsUp,      1'b0);
        check({tag, "_PlaneOnGround"}, gif.PlaneOnGround, 1'b1);
        check({tag, "_TimeUp"},        gif.TimeUp,        1'b0);
        check({tag, "_SensorFault"},   gif.SensorFault,   1'b0);
    endtask

    // Called at a falling edge: assert Clear mid-cycle, verify outputs without a clock edge.
    task automatic do_clear();
        #2 Clear = 1'b1;
        #1 check_reset_outputs("async_clear");
        model_reset();
        @(negedge Clock);
        Clear = 1'b0;
    endtask

    task automatic drive(input logic lv, input logic dn, input logic up, input logic pg, input logic tm);
        gif.LeverRaw         = lv;
        gif.GearIsDownRaw    = dn;
        gif.GearIsUpRaw      = up;
        gif.PlaneOnGroundRaw = pg;
        gif.Timer            = tm;
    endtask

    initial begin
        // lever down up pog timer hold | Lever Down Up Pog TimeUp Fault
        tbl[0]  = '{1,1,0,1,1, 1, 1,1,0,1,0,0};
        tbl[1]  = '{0,1,0,1,1, 2, 1,1,0,1,0,0};
        tbl[2]  = '{0,1,0,1,1, 8, 1,1,0,1,0,0};
        tbl[3]  = '{0,1,0,1,1, 1, 0,1,0,1,0,0};
        tbl[4]  = '{0,1,0,0,1, 6, 0,1,0,1,0,0};
        tbl[5]  = '{0,1,0,1,1,10, 0,1,0,1,0,0};
        tbl[6]  = '{0,1,0,1,1, 4, 0,1,0,1,0,0};
        tbl[7]  = '{0,1,0,1,0,19, 0,1,0,1,0,0};
        tbl[8]  = '{0,1,0,1,0, 1, 0,1,0,1,1,0};
        tbl[9]  = '{0,1,0,1,0, 8, 0,1,0,1,1,0};
        tbl[10] = '{0,1,0,1,1, 1, 0,1,0,1,0,0};
        tbl[11] = '{0,1,0,1,0,12, 0,1,0,1,0,0};
        tbl[12] = '{0,1,0,1,1, 1, 0,1,0,1,0,0};
        tbl[13] = '{0,1,0,1,0,17, 0,1,0,1,0,0};
        tbl[14] = '{0,1,0,1,0, 1, 0,1,0,1,1,0};
        tbl[15] = '{0,1,0,1,1, 1, 0,1,0,1,0,0};
        tbl[16] = '{0,1,0,1,0,10, 0,1,0,1,0,0};
        tbl[17] = '{0,1,0,1,1, 1, 0,1,0,1,0,0};
        tbl[18] = '{0,1,0,1,0,19, 0,1,0,1,0,0};
        tbl[19] = '{0,1,0,1,0, 1, 0,1,0,1,1,0};
        tbl[20] = '{0,1,1,1,1,12, 0,1,1,1,0,0};
        tbl[21] = '{0,1,1,1,1, 1, 0,1,1,1,0,1};
        tbl[22] = '{0,1,0,1,1,20, 0,1,0,1,0,1};

        Clear = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        #1 Clear = 1'b1;
        #1 check_reset_outputs("power_on_reset");
        model_reset();
        @(negedge Clock);
        Clear = 1'b0;

`ifndef GEAR_COND_DB_BYPASS_EN
        for (int e = 0; e < NV; e++) begin
            drive(tbl[e].lever, tbl[e].down, tbl[e].up, tbl[e].pog, tbl[e].timer);
            for (int c = 0; c < tbl[e].hold; c++) step();
            check($sformatf("vec%0d_Lever", e),         gif.Lever,         tbl[e].e_lever);
            check($sformatf("vec%0d_GearIsDown", e),    gif.GearIsDown,    tbl[e].e_down);
            check($sformatf("vec%0d_GearIsUp", e),      gif.GearIsUp,      tbl[e].e_up);
            check($sformatf("vec%0d_PlaneOnGround", e), gif.PlaneOnGround, tbl[e].e_pog);
            check($sformatf("vec%0d_TimeUp", e),        gif.TimeUp,        tbl[e].e_timeup);
            check($sformatf("vec%0d_SensorFault", e),   gif.SensorFault,   tbl[e].e_fault);
        end
`endif

        // Lever is 0 and SensorFault is 1 here; an async Clear must restore both at once.
        do_clear();

        // Random stimulus: slow raw toggles so debounce both rejects and accepts changes.
        for (int n = 0; n < 3000; n++) begin
            if (n > 0 && (n % 1000) == 0) do_clear();
            if ($urandom_range(11) == 0) gif.LeverRaw         = ~gif.LeverRaw;
            if ($urandom_range(11) == 0) gif.GearIsDownRaw    = ~gif.GearIsDownRaw;
            if ($urandom_range(11) == 0) gif.GearIsUpRaw      = ~gif.GearIsUpRaw;
            if ($urandom_range(11) == 0) gif.PlaneOnGroundRaw = ~gif.PlaneOnGroundRaw;
            if (gif.Timer) begin
                if ($urandom_range(3) == 0) gif.Timer = 1'b0;
            end else begin
                if ($urandom_range(39) == 0) gif.Timer = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
